// File: rtl/son_cfg_writer.sv
`default_nettype none
// ============================================================================
// Module   : son_cfg_writer
// Purpose  : Write-side source for the per-son configuration buses.
//            A host fills three shadow registers over a valid/ready port and
//            commits them; the shadow set is copied to all three active cfg
//            outputs together on the next frame_sync pulse, so no son ever
//            observes a partially updated configuration. After an apply the
//            write port stays blocked for HOLD_CYC cycles.
// Options  : `define SON_CFG_READBACK_EN adds a registered readback port
//            (rd_addr / rd_sel / rd_data) for shadow or active values.
// Revision : 1.0 - initial release
// ============================================================================
module son_cfg_writer #(
  parameter int CFG_W    = 4,
  parameter int HOLD_CYC = 2   // legal range 0..15 (4-bit hold counter)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [1:0]       wr_addr,
  input  logic [CFG_W-1:0] wr_data,
  input  logic             commit,
  input  logic             frame_sync,
  input  logic             err_clr,
  output logic [CFG_W-1:0] cfg_of_son1,
  output logic [CFG_W-1:0] cfg_of_son2,
  output logic [CFG_W-1:0] cfg_of_son3,
  output logic             cfg_upd,
  output logic             busy,
`ifdef SON_CFG_READBACK_EN
  input  logic [1:0]       rd_addr,
  input  logic             rd_sel,
  output logic [CFG_W-1:0] rd_data,
`endif
  output logic             err_addr
);

  // FSM encoding
  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ARMED  = 2'd1;
  localparam logic [1:0] c_SETTLE = 2'd2;

  // Hold length loaded into the settle counter on every apply
  localparam logic [3:0] c_HOLD = 4'(HOLD_CYC);

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic [CFG_W-1:0] r_shadow0;
  logic [CFG_W-1:0] r_shadow1;
  logic [CFG_W-1:0] r_shadow2;
  logic [CFG_W-1:0] r_cfg1;
  logic [CFG_W-1:0] r_cfg2;
  logic [CFG_W-1:0] r_cfg3;
  logic             r_upd;
  logic             r_err;

  logic             w_idle;
  logic             w_wr_acc;
  logic             w_wr_bad;
  logic             w_apply;

  // Writes are only taken in IDLE; address 3 is accepted but flagged
  assign w_idle   = (r_state == c_IDLE);
  assign w_wr_acc = wr_valid & w_idle;
  assign w_wr_bad = w_wr_acc & (wr_addr == 2'd3);
  assign w_apply  = (r_state == c_ARMED) & frame_sync;

  // Control FSM: IDLE -> ARMED on commit, ARMED -> SETTLE/IDLE on frame_sync
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          // frame_sync is ignored here, even when it coincides with commit
          if (commit) begin
            r_state <= c_ARMED;
          end
        end
        c_ARMED: begin
          // A second commit while armed is simply dropped
          if (frame_sync) begin
            if (c_HOLD == 4'd0) begin
              r_state <= c_IDLE;
            end else begin
              r_state <= c_SETTLE;
              r_cnt   <= c_HOLD;
            end
          end
        end
        c_SETTLE: begin
          // Leave on the edge where the counter reads 1: HOLD_CYC cycles total
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            r_state <= c_IDLE;
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Shadow registers: updated by accepted writes only, never by an apply
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow0 <= '0;
      r_shadow1 <= '0;
      r_shadow2 <= '0;
    end else if (w_wr_acc) begin
      case (wr_addr)
        2'd0:    r_shadow0 <= wr_data;
        2'd1:    r_shadow1 <= wr_data;
        2'd2:    r_shadow2 <= wr_data;
        default: ;  // invalid target: data dropped, error flagged below
      endcase
    end
  end

  // Active outputs: all three copied together on apply, plus one-cycle pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg1 <= '0;
      r_cfg2 <= '0;
      r_cfg3 <= '0;
      r_upd  <= 1'b0;
    end else begin
      r_upd <= w_apply;
      if (w_apply) begin
        r_cfg1 <= r_shadow0;
        r_cfg2 <= r_shadow1;
        r_cfg3 <= r_shadow2;
      end
    end
  end

  // Sticky invalid-address flag; a new error outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_wr_bad) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

`ifdef SON_CFG_READBACK_EN
  logic [CFG_W-1:0] r_rd_data;

  // Registered readback; sampling pre-edge registers returns the old value
  // when a write to the same shadow lands in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else begin
      case (rd_addr)
        2'd0:    r_rd_data <= rd_sel ? r_cfg1 : r_shadow0;
        2'd1:    r_rd_data <= rd_sel ? r_cfg2 : r_shadow1;
        2'd2:    r_rd_data <= rd_sel ? r_cfg3 : r_shadow2;
        default: r_rd_data <= '0;
      endcase
    end
  end

  assign rd_data = r_rd_data;
`endif

  assign wr_ready    = w_idle;
  assign busy        = ~w_idle;
  assign cfg_of_son1 = r_cfg1;
  assign cfg_of_son2 = r_cfg2;
  assign cfg_of_son3 = r_cfg3;
  assign cfg_upd     = r_upd;
  assign err_addr    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_son_cfg_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_son_cfg_writer
// Purpose  : Self-checking bench for son_cfg_writer. Directed scenarios plus
//            random traffic, compared every cycle with a transaction-level
//            reference model of the shadow/commit/apply behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_son_cfg_writer;

  localparam int CFG_W = 4;
  localparam int HOLD  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [1:0]       wr_addr = 2'd0;
  logic [CFG_W-1:0] wr_data = '0;
  logic             commit = 1'b0;
  logic             frame_sync = 1'b0;
  logic             err_clr = 1'b0;
  logic [CFG_W-1:0] cfg_of_son1;
  logic [CFG_W-1:0] cfg_of_son2;
  logic [CFG_W-1:0] cfg_of_son3;
  logic             cfg_upd;
  logic             busy;
  logic             err_addr;
`ifdef SON_CFG_READBACK_EN
  logic [1:0]       rd_addr = 2'd0;
  logic             rd_sel = 1'b0;
  logic [CFG_W-1:0] rd_data;
`endif

  int n_chk = 0;
  int n_err = 0;

  son_cfg_writer #(.CFG_W(CFG_W), .HOLD_CYC(HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit      (commit),
    .frame_sync  (frame_sync),
    .err_clr     (err_clr),
    .cfg_of_son1 (cfg_of_son1),
    .cfg_of_son2 (cfg_of_son2),
    .cfg_of_son3 (cfg_of_son3),
    .cfg_upd     (cfg_upd),
    .busy        (busy),
`ifdef SON_CFG_READBACK_EN
    .rd_addr     (rd_addr),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data),
`endif
    .err_addr    (err_addr)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // phase: 0 = accepting writes, 1 = waiting for a frame boundary,
  //        2 = blocked for m_left more cycles after an apply
  int         m_phase = 0;
  int         m_left  = 0;
  logic [3:0] m_sh [3];
  logic [3:0] m_act[3];
  logic       m_upd = 1'b0;
  logic       m_err = 1'b0;
  logic [3:0] m_rd  = 4'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_left  = 0;
    for (int i = 0; i < 3; i++) begin
      m_sh[i]  = 4'h0;
      m_act[i] = 4'h0;
    end
    m_upd = 1'b0;
    m_err = 1'b0;
    m_rd  = 4'h0;
  endtask

  // Advance the model by one clock using the inputs present at the edge
  task automatic model_step();
    logic       bad;
    if (rst) begin
      model_reset();
    end else begin
`ifdef SON_CFG_READBACK_EN
      if (rd_addr == 2'd3)  m_rd = 4'h0;
      else if (rd_sel)      m_rd = m_act[int'(rd_addr)];
      else                  m_rd = m_sh[int'(rd_addr)];
`endif
      bad   = 1'b0;
      m_upd = 1'b0;
      if (m_phase == 0) begin
        if (wr_valid) begin
          if (wr_addr == 2'd3) bad = 1'b1;
          else m_sh[int'(wr_addr)] = wr_data;
        end
        if (commit) m_phase = 1;
      end else if (m_phase == 1) begin
        if (frame_sync) begin
          for (int i = 0; i < 3; i++) m_act[i] = m_sh[i];
          m_upd = 1'b1;
          if (HOLD == 0) m_phase = 0;
          else begin
            m_phase = 2;
            m_left  = HOLD;
          end
        end
      end else begin
        m_left--;
        if (m_left == 0) m_phase = 0;
      end
      if (bad)          m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
  endtask

  task automatic check_all();
    check("cfg1",  32'(cfg_of_son1), 32'(m_act[0]));
    check("cfg2",  32'(cfg_of_son2), 32'(m_act[1]));
    check("cfg3",  32'(cfg_of_son3), 32'(m_act[2]));
    check("upd",   32'(cfg_upd),     32'(m_upd));
    check("busy",  32'(busy),        32'(m_phase != 0));
    check("ready", 32'(wr_ready),    32'(m_phase == 0));
    check("err",   32'(err_addr),    32'(m_err));
`ifdef SON_CFG_READBACK_EN
    check("rdata", 32'(rd_data),     32'(m_rd));
`endif
  endtask

  // Drive one cycle of inputs, clock it, update model, check at negedge
  task automatic cyc(input logic r, input logic v, input logic [1:0] a,
                     input logic [3:0] d, input logic c, input logic f,
                     input logic e);
    rst        = r;
    wr_valid   = v;
    wr_addr    = a;
    wr_data    = d;
    commit     = c;
    frame_sync = f;
    err_clr    = e;
`ifdef SON_CFG_READBACK_EN
    rd_addr    = 2'($urandom_range(0, 3));
    rd_sel     = 1'($urandom_range(0, 1));
`endif
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 2'd0, 4'h0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    // reset
    cyc(1, 0, 2'd0, 4'h0, 0, 0, 0);
    cyc(1, 0, 2'd0, 4'h0, 0, 0, 0);
    idle(1);
    // basic load / commit / apply
    cyc(0, 1, 2'd0, 4'h3, 0, 0, 0);
    cyc(0, 1, 2'd1, 4'h5, 0, 0, 0);
    cyc(0, 1, 2'd2, 4'hA, 0, 0, 0);
    cyc(0, 0, 2'd0, 4'h0, 1, 0, 0);
    idle(2);
    cyc(0, 0, 2'd0, 4'h0, 0, 1, 0);
    idle(4);
    // invalid address handling, set beats clear
    cyc(0, 1, 2'd3, 4'hF, 0, 0, 0);
    cyc(0, 1, 2'd3, 4'hF, 0, 0, 1);
    cyc(0, 0, 2'd0, 4'h0, 0, 0, 1);
    // commit and frame_sync together: arm only
    cyc(0, 1, 2'd1, 4'h7, 0, 0, 0);
    cyc(0, 0, 2'd0, 4'h0, 1, 1, 0);
    idle(4);
    cyc(0, 0, 2'd0, 4'h0, 0, 1, 0);
    idle(3);
    // write + second commit while armed are ignored
    cyc(0, 1, 2'd0, 4'h1, 1, 0, 0);
    cyc(0, 1, 2'd2, 4'h9, 1, 0, 0);
    cyc(0, 0, 2'd0, 4'h0, 0, 1, 0);
    idle(4);
    // reset while armed abandons the commit
    cyc(0, 0, 2'd0, 4'h0, 1, 0, 0);
    idle(1);
    cyc(1, 0, 2'd0, 4'h0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 2'd0, 4'h0, 0, 1, 0);
    idle(2);
    // re-commit with no writes still pulses cfg_upd
    cyc(0, 1, 2'd0, 4'hC, 1, 0, 0);
    cyc(0, 0, 2'd0, 4'h0, 0, 1, 0);
    idle(3);
    cyc(0, 0, 2'd0, 4'h0, 1, 0, 0);
    cyc(0, 0, 2'd0, 4'h0, 0, 1, 0);
    idle(3);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 63) == 0),
          1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)),
          4'($urandom_range(0, 15)),
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 7) == 0));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
